// File: rtl/ibex_pkg.sv
// Shared PMP types: CSR layouts, access/privilege encodings, fault record
// and the small permission helpers used by the per-channel decision logic.
package ibex_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  localparam int unsigned PMP_MAX_REGIONS  = 16;
  localparam int unsigned PMP_MAX_CHAN     = 4;
  // Fault address field is wide enough for any supported physical address
  localparam int unsigned PMP_FAULT_ADDR_W = 64;

  typedef struct packed {
    logic [PMP_FAULT_ADDR_W-1:0] addr;
    pmp_req_e                    req_type;
    priv_lvl_e                   priv;
    logic [1:0]                  chan;
  } pmp_fault_t;

  // Permission bit of a region config that corresponds to an access type
  function automatic logic perm_bit(pmp_cfg_t cfg, pmp_req_e req_type);
    logic bit_val;
    case (req_type)
      PMP_ACC_EXEC:  bit_val = cfg.exec;
      PMP_ACC_WRITE: bit_val = cfg.write;
      PMP_ACC_READ:  bit_val = cfg.read;
      default:       bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

  // Smepmp machine-mode-lockdown permission for a matched region
  function automatic logic mml_allow(pmp_cfg_t cfg, pmp_req_e req_type, logic m_mode);
    logic r_req;
    logic w_req;
    logic x_req;
    logic ok;
    r_req = (req_type == PMP_ACC_READ);
    w_req = (req_type == PMP_ACC_WRITE);
    x_req = (req_type == PMP_ACC_EXEC);
    if ({cfg.lock, cfg.read, cfg.write, cfg.exec} == 4'b1111) begin
      // shared read-only for every mode
      ok = r_req;
    end else if (!cfg.read && cfg.write) begin
      // shared-region encodings
      case ({cfg.lock, cfg.exec})
        2'b00:   ok = r_req | (w_req & m_mode);
        2'b01:   ok = r_req | w_req;
        2'b10:   ok = x_req;
        2'b11:   ok = x_req | (r_req & m_mode);
        default: ok = 1'b0;
      endcase
    end else if (cfg.lock == m_mode) begin
      // locked regions serve M-mode only, unlocked serve S/U only
      ok = perm_bit(cfg, req_type);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ibex_pmp_decide.sv
// Combinational PMP decision for a single request: region matching
// (TOR/NA4/NAPOT), lowest-index priority and the permission rules.
module ibex_pmp_decide
  import ibex_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 16,
  parameter int unsigned PMPAddrWidth   = 34,
  localparam int unsigned RegIdxW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1
) (
  input  pmp_cfg_t                 csr_cfg  [PMPNumRegions],
  input  logic [PMPAddrWidth-1:0]  csr_addr [PMPNumRegions],
  input  pmp_mseccfg_t             mseccfg,
  input  logic [PMPAddrWidth-1:0]  req_addr,
  input  pmp_req_e                 req_type,
  input  priv_lvl_e                priv,
  output logic                     err,
  output logic                     hit,
  output logic [RegIdxW-1:0]       region
);

  localparam int unsigned GRAN_BITS = PMPGranularity + 2;
  localparam logic [PMPAddrWidth-1:0] GRAN_MASK =
    {{(PMPAddrWidth-GRAN_BITS){1'b1}}, {GRAN_BITS{1'b0}}};

  logic [PMPAddrWidth-1:0]  addr_g;
  logic [PMPAddrWidth-1:0]  base [PMPNumRegions];
  logic [PMPNumRegions-1:0] match;
  pmp_cfg_t                 sel_cfg;
  logic                     m_mode;
  logic                     unused_rlb;

  assign addr_g     = req_addr & GRAN_MASK;
  assign m_mode     = (priv == PRIV_LVL_M);
  assign unused_rlb = mseccfg.rlb;

  // Address bits that must compare equal for a NAPOT region: everything above
  // the run of trailing ones (granule bits count as ones)
  function automatic logic [PMPAddrWidth-1:0] napot_care(logic [PMPAddrWidth-1:0] a);
    logic                    run;
    logic [PMPAddrWidth-1:0] care;
    care = {PMPAddrWidth{1'b0}};
    run  = 1'b1;
    for (int i = 2; i < int'(PMPAddrWidth); i++) begin
      care[i] = ~run;
      run     = run & (a[i] | (i < int'(GRAN_BITS)));
    end
    return care;
  endfunction

  // TOR lower bounds: region 0 starts at address zero
  always_comb begin
    base[0] = {PMPAddrWidth{1'b0}};
    for (int r = 1; r < int'(PMPNumRegions); r++) begin
      base[r] = csr_addr[r-1] & GRAN_MASK;
    end
  end

  // Per-region address match
  always_comb begin
    logic [PMPAddrWidth-1:0] top;
    logic [PMPAddrWidth-1:0] care;
    match = {PMPNumRegions{1'b0}};
    top   = {PMPAddrWidth{1'b0}};
    care  = {PMPAddrWidth{1'b0}};
    for (int r = 0; r < int'(PMPNumRegions); r++) begin
      top  = csr_addr[r] & GRAN_MASK;
      care = napot_care(csr_addr[r]);
      case (csr_cfg[r].mode)
        PMP_MODE_OFF:   match[r] = 1'b0;
        PMP_MODE_TOR:   match[r] = (addr_g >= base[r]) && (addr_g < top);
        PMP_MODE_NA4:   match[r] = (PMPGranularity == 0) &&
                                   (addr_g[PMPAddrWidth-1:2] == csr_addr[r][PMPAddrWidth-1:2]);
        PMP_MODE_NAPOT: match[r] = (((addr_g ^ csr_addr[r]) & care) == {PMPAddrWidth{1'b0}});
        default:        match[r] = 1'b0;
      endcase
    end
  end

  // Lowest matching region decides; then apply default or region permissions
  always_comb begin
    hit     = 1'b0;
    region  = {RegIdxW{1'b0}};
    sel_cfg = '0;
    for (int r = 0; r < int'(PMPNumRegions); r++) begin
      region  = (match[r] && !hit) ? RegIdxW'(r) : region;
      sel_cfg = (match[r] && !hit) ? csr_cfg[r] : sel_cfg;
      hit     = hit | match[r];
    end
    if (!hit) begin
      err = mseccfg.mmwp | ~m_mode | (mseccfg.mml & (req_type == PMP_ACC_EXEC));
    end else if (mseccfg.mml) begin
      err = ~mml_allow(sel_cfg, req_type, m_mode);
    end else begin
      err = ~(perm_bit(sel_cfg, req_type) | (m_mode & ~sel_cfg.lock));
    end
  end

endmodule

// File: rtl/ibex_pmp_checker.sv
// Registered multi-channel PMP checker: one decision per channel, a one-entry
// response stage per channel and a sticky first-fault capture register.
module ibex_pmp_checker
  import ibex_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumChan     = 2,
  parameter int unsigned PMPNumRegions  = 16,
  parameter int unsigned PMPAddrWidth   = 34,
  localparam int unsigned RegIdxW  = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1,
  localparam int unsigned ChanIdxW = (PMPNumChan > 1) ? $clog2(PMPNumChan) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  pmp_cfg_t                 csr_pmp_cfg_i     [PMPNumRegions],
  input  logic [PMPAddrWidth-1:0]  csr_pmp_addr_i    [PMPNumRegions],
  input  pmp_mseccfg_t             csr_pmp_mseccfg_i,
  input  logic [PMPNumChan-1:0]    req_valid_i,
  output logic [PMPNumChan-1:0]    req_ready_o,
  input  logic [PMPAddrWidth-1:0]  req_addr_i        [PMPNumChan],
  input  pmp_req_e                 req_type_i        [PMPNumChan],
  input  priv_lvl_e                priv_mode_i       [PMPNumChan],
  output logic [PMPNumChan-1:0]    rsp_valid_o,
  input  logic [PMPNumChan-1:0]    rsp_ready_i,
  output logic [PMPNumChan-1:0]    rsp_err_o,
  output logic [PMPNumChan-1:0]    rsp_hit_o,
  output logic [RegIdxW-1:0]       rsp_region_o      [PMPNumChan],
  output logic                     fault_valid_o,
  output logic [PMPAddrWidth-1:0]  fault_addr_o,
  output pmp_req_e                 fault_type_o,
  output priv_lvl_e                fault_priv_o,
  output logic [ChanIdxW-1:0]      fault_chan_o,
  output logic                     fault_overflow_o,
  input  logic                     fault_clear_i
);

  logic [PMPNumChan-1:0] dec_err;
  logic [PMPNumChan-1:0] load;
  logic [PMPNumChan-1:0] new_fault;
  logic                  new_any;
  logic                  new_multi;
  pmp_fault_t            new_rec;
  pmp_fault_t            fault_q;
  logic                  fault_valid_q;
  logic                  fault_ovf_q;
  logic                  unused_fault_bits;

  for (genvar c = 0; c < int'(PMPNumChan); c++) begin : g_chan
    logic               dec_hit;
    logic [RegIdxW-1:0] dec_region;
    logic               valid_q;
    logic               err_q;
    logic               hit_q;
    logic [RegIdxW-1:0] region_q;

    ibex_pmp_decide #(
      .PMPGranularity (PMPGranularity),
      .PMPNumRegions  (PMPNumRegions),
      .PMPAddrWidth   (PMPAddrWidth)
    ) u_decide (
      .csr_cfg  (csr_pmp_cfg_i),
      .csr_addr (csr_pmp_addr_i),
      .mseccfg  (csr_pmp_mseccfg_i),
      .req_addr (req_addr_i[c]),
      .req_type (req_type_i[c]),
      .priv     (priv_mode_i[c]),
      .err      (dec_err[c]),
      .hit      (dec_hit),
      .region   (dec_region)
    );

    assign req_ready_o[c]  = ~valid_q | rsp_ready_i[c];
    assign load[c]         = req_valid_i[c] & req_ready_o[c];
    assign rsp_valid_o[c]  = valid_q;
    assign rsp_err_o[c]    = err_q;
    assign rsp_hit_o[c]    = hit_q;
    assign rsp_region_o[c] = region_q;

    // One-entry response stage: load on accept, drain on handover
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
        hit_q    <= 1'b0;
        region_q <= {RegIdxW{1'b0}};
      end else if (load[c]) begin
        valid_q  <= 1'b1;
        err_q    <= dec_err[c];
        hit_q    <= dec_hit;
        region_q <= dec_region;
      end else if (rsp_ready_i[c]) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign new_fault = load & dec_err;

  // Select the lowest-index channel loading an error this cycle
  always_comb begin
    new_any   = 1'b0;
    new_multi = 1'b0;
    new_rec   = '0;
    for (int c = 0; c < int'(PMPNumChan); c++) begin
      new_multi = new_multi | (new_fault[c] & new_any);
      if (new_fault[c] && !new_any) begin
        new_rec.addr     = PMP_FAULT_ADDR_W'(req_addr_i[c]);
        new_rec.req_type = req_type_i[c];
        new_rec.priv     = priv_mode_i[c];
        new_rec.chan     = 2'(c);
      end else begin
        new_rec = new_rec;
      end
      new_any = new_any | new_fault[c];
    end
  end

  // Sticky fault record: capture when free (or being cleared), else flag overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_q <= 1'b0;
      fault_ovf_q   <= 1'b0;
      fault_q       <= '0;
    end else if (new_any && (!fault_valid_q || fault_clear_i)) begin
      fault_valid_q <= 1'b1;
      fault_ovf_q   <= new_multi;
      fault_q       <= new_rec;
    end else if (new_any) begin
      fault_ovf_q   <= 1'b1;
    end else if (fault_clear_i) begin
      fault_valid_q <= 1'b0;
      fault_ovf_q   <= 1'b0;
    end
  end

  assign fault_valid_o     = fault_valid_q;
  assign fault_overflow_o  = fault_ovf_q;
  assign fault_addr_o      = fault_q.addr[PMPAddrWidth-1:0];
  assign fault_type_o      = fault_q.req_type;
  assign fault_priv_o      = fault_q.priv;
  assign fault_chan_o      = fault_q.chan[ChanIdxW-1:0];
  assign unused_fault_bits = ^{fault_q.addr, fault_q.chan};

endmodule

// File: tb/tb_ibex_pmp_checker.sv
// Self-checking bench for ibex_pmp_checker: directed scenarios plus random
// traffic against a table-driven reference model of the PMP rules.
`timescale 1ns/1ps
module tb_ibex_pmp_checker;
  import ibex_pkg::*;

  localparam int NR = 16;
  localparam int NC = 2;
  localparam int AW = 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmp_cfg_t      cfg   [NR];
  logic [AW-1:0] paddr [NR];
  pmp_mseccfg_t  msec;
  logic [NC-1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, rsp_hit;
  logic [AW-1:0] req_addr [NC];
  pmp_req_e      req_type [NC];
  priv_lvl_e     priv     [NC];
  logic [3:0]    rsp_region [NC];
  logic          fault_valid, fault_overflow, fault_clear;
  logic [AW-1:0] fault_addr;
  pmp_req_e      fault_type;
  priv_lvl_e     fault_priv;
  logic [0:0]    fault_chan;

  ibex_pmp_checker #(
    .PMPGranularity (0),
    .PMPNumChan     (NC),
    .PMPNumRegions  (NR),
    .PMPAddrWidth   (AW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .csr_pmp_cfg_i     (cfg),
    .csr_pmp_addr_i    (paddr),
    .csr_pmp_mseccfg_i (msec),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_type_i        (req_type),
    .priv_mode_i       (priv),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_err_o         (rsp_err),
    .rsp_hit_o         (rsp_hit),
    .rsp_region_o      (rsp_region),
    .fault_valid_o     (fault_valid),
    .fault_addr_o      (fault_addr),
    .fault_type_o      (fault_type),
    .fault_priv_o      (fault_priv),
    .fault_chan_o      (fault_chan),
    .fault_overflow_o  (fault_overflow),
    .fault_clear_i     (fault_clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Smepmp MML table indexed by {L,R,W,X}: {M-mode rwx, S/U-mode rwx}
  localparam logic [5:0] MML_TAB [16] = '{
    6'b000_000, 6'b000_001, 6'b110_100, 6'b110_110,
    6'b000_100, 6'b000_101, 6'b000_110, 6'b000_111,
    6'b000_000, 6'b001_000, 6'b001_001, 6'b101_001,
    6'b100_000, 6'b101_000, 6'b110_000, 6'b100_100
  };

  // Reference model state
  bit        m_valid [NC];
  bit        m_err   [NC];
  bit        m_hit   [NC];
  int        m_region[NC];
  bit        m_fv, m_ov;
  logic [AW-1:0] m_faddr;
  pmp_req_e  m_ftype;
  priv_lvl_e m_fpriv;
  int        m_fchan;

  function automatic pmp_cfg_t mk_cfg(bit l, pmp_cfg_mode_e md, bit r, bit w, bit x);
    pmp_cfg_t c;
    c.lock = l; c.mode = md; c.read = r; c.write = w; c.exec = x;
    return c;
  endfunction

  function automatic bit region_match(int r, logic [AW-1:0] a);
    longint unsigned av, lo, hi, pa, size, ra;
    int t;
    av = {30'd0, a} & ~64'h3;
    ra = {30'd0, paddr[r]};
    case (cfg[r].mode)
      PMP_MODE_TOR: begin
        if (r == 0) lo = 64'd0;
        else lo = {30'd0, paddr[r-1]} & ~64'h3;
        hi = ra & ~64'h3;
        return (av >= lo) && (av < hi);
      end
      PMP_MODE_NA4: return (av >> 2) == (ra >> 2);
      PMP_MODE_NAPOT: begin
        pa = ra >> 2;
        t = 0;
        while (t < 40 && pa[t]) t++;
        size = 64'd1 << (t + 3);
        return (av / size) == (ra / size);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic ref_decide(input logic [AW-1:0] a, input pmp_req_e ty, input priv_lvl_e pv,
                            output bit err, output bit hit, output int rg);
    logic [5:0] row;
    logic [2:0] perms, need;
    bit mm;
    hit = 1'b0; rg = 0;
    for (int r = 0; r < NR; r++) if (!hit && region_match(r, a)) begin hit = 1'b1; rg = r; end
    mm = (pv == PRIV_LVL_M);
    need = (ty == PMP_ACC_READ) ? 3'b100 : (ty == PMP_ACC_WRITE) ? 3'b010 : 3'b001;
    if (!hit) begin
      err = msec.mmwp || !mm || (msec.mml && ty == PMP_ACC_EXEC);
    end else if (msec.mml) begin
      row = MML_TAB[{cfg[rg].lock, cfg[rg].read, cfg[rg].write, cfg[rg].exec}];
      perms = mm ? row[5:3] : row[2:0];
      err = ((perms & need) == 3'b000);
    end else begin
      perms = {cfg[rg].read, cfg[rg].write, cfg[rg].exec};
      if (mm && !cfg[rg].lock) perms = 3'b111;
      err = ((perms & need) == 3'b000);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s rsp_valid%0d", tag, c), rsp_valid[c], m_valid[c]);
      if (m_valid[c]) begin
        chk($sformatf("%s rsp_err%0d", tag, c), rsp_err[c], m_err[c]);
        chk($sformatf("%s rsp_hit%0d", tag, c), rsp_hit[c], m_hit[c]);
        chk($sformatf("%s rsp_region%0d", tag, c), rsp_region[c], m_region[c]);
      end
    end
    chk({tag, " fault_valid"}, fault_valid, m_fv);
    chk({tag, " fault_overflow"}, fault_overflow, m_ov);
    if (m_fv) begin
      chk({tag, " fault_addr"}, fault_addr, m_faddr);
      chk({tag, " fault_type"}, fault_type, m_ftype);
      chk({tag, " fault_priv"}, fault_priv, m_fpriv);
      chk({tag, " fault_chan"}, fault_chan, m_fchan);
    end
  endtask

  // One clock: check ready, advance the model, clock, check outputs
  task automatic cycle(input string tag);
    bit e, h;
    int rg, nf;
    logic [AW-1:0] ca;
    pmp_req_e ct;
    priv_lvl_e cp;
    int cc;
    #1;
    for (int c = 0; c < NC; c++)
      chk($sformatf("%s req_ready%0d", tag, c), req_ready[c], !m_valid[c] || rsp_ready[c]);
    nf = 0; ca = '0; ct = PMP_ACC_EXEC; cp = PRIV_LVL_U; cc = 0;
    for (int c = 0; c < NC; c++) begin
      if (req_valid[c] && (!m_valid[c] || rsp_ready[c])) begin
        ref_decide(req_addr[c], req_type[c], priv[c], e, h, rg);
        m_valid[c] = 1'b1; m_err[c] = e; m_hit[c] = h; m_region[c] = rg;
        if (e) begin
          if (nf == 0) begin ca = req_addr[c]; ct = req_type[c]; cp = priv[c]; cc = c; end
          nf++;
        end
      end else if (rsp_ready[c]) begin
        m_valid[c] = 1'b0;
      end
    end
    if (nf > 0 && (!m_fv || fault_clear)) begin
      m_fv = 1'b1; m_ov = (nf > 1); m_faddr = ca; m_ftype = ct; m_fpriv = cp; m_fchan = cc;
    end else if (nf > 0) begin
      m_ov = 1'b1;
    end else if (fault_clear) begin
      m_fv = 1'b0; m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_csrs();
    for (int r = 0; r < NR; r++) begin cfg[r] = '0; paddr[r] = '0; end
    msec = '0;
  endtask

  task automatic idle();
    req_valid = '0; rsp_ready = '1; fault_clear = 1'b0;
  endtask

  task automatic set_req(input int c, input logic [AW-1:0] a, input pmp_req_e t, input priv_lvl_e p);
    req_valid[c] = 1'b1; req_addr[c] = a; req_type[c] = t; priv[c] = p;
  endtask

  task automatic rand_csrs();
    int k;
    longint unsigned size, b;
    for (int r = 0; r < NR; r++) begin
      cfg[r] = mk_cfg($urandom_range(0, 1), pmp_cfg_mode_e'($urandom_range(0, 3)),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      paddr[r] = AW'($urandom_range(0, 32'h5000));
      if (cfg[r].mode == PMP_MODE_NAPOT) begin
        k = $urandom_range(0, 10);
        size = 64'd1 << (k + 3);
        b = longint'($urandom_range(0, 32'h5000)) & ~(size - 64'd1);
        paddr[r] = AW'((b >> 2 | ((size >> 3) - 64'd1)) << 2);
      end
    end
    msec.mml  = ($urandom_range(0, 2) == 0);
    msec.mmwp = ($urandom_range(0, 3) == 0);
    msec.rlb  = $urandom_range(0, 1);
  endtask

  function automatic priv_lvl_e rand_priv();
    int p;
    p = $urandom_range(0, 2);
    return (p == 0) ? PRIV_LVL_U : (p == 1) ? PRIV_LVL_S : PRIV_LVL_M;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NC; c++) begin m_valid[c] = 1'b0; m_err[c] = 1'b0; m_hit[c] = 1'b0; m_region[c] = 0; end
    m_fv = 1'b0; m_ov = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s rst rsp_valid%0d", tag, c), rsp_valid[c], 1'b0);
      chk($sformatf("%s rst rsp_err%0d", tag, c), rsp_err[c], 1'b0);
      chk($sformatf("%s rst rsp_hit%0d", tag, c), rsp_hit[c], 1'b0);
      chk($sformatf("%s rst rsp_region%0d", tag, c), rsp_region[c], 4'd0);
      chk($sformatf("%s rst req_ready%0d", tag, c), req_ready[c], 1'b1);
    end
    chk({tag, " rst fault_valid"}, fault_valid, 1'b0);
    chk({tag, " rst fault_overflow"}, fault_overflow, 1'b0);
    chk({tag, " rst fault_addr"}, fault_addr, 34'd0);
    chk({tag, " rst fault_type"}, fault_type, 2'd0);
    chk({tag, " rst fault_priv"}, fault_priv, 2'd0);
    chk({tag, " rst fault_chan"}, fault_chan, 1'd0);
  endtask

  initial begin
    clear_csrs();
    idle();
    rsp_ready = '0;
    for (int c = 0; c < NC; c++) begin req_addr[c] = '0; req_type[c] = PMP_ACC_READ; priv[c] = PRIV_LVL_M; end
    reset_model();
    #12;
    check_reset_state("init");
    rst_n = 1'b1;
    rsp_ready = '1;

    // All regions off: M-mode allowed, U-mode denied and logged
    set_req(0, 34'h1000, PMP_ACC_READ, PRIV_LVL_M);
    cycle("off_m");
    chk("off_m err", rsp_err[0], 1'b0);
    chk("off_m hit", rsp_hit[0], 1'b0);
    chk("off_m region", rsp_region[0], 4'd0);
    set_req(0, 34'h1000, PMP_ACC_READ, PRIV_LVL_U);
    cycle("off_u");
    chk("off_u err", rsp_err[0], 1'b1);
    chk("off_u fault_valid", fault_valid, 1'b1);
    chk("off_u fault_addr", fault_addr, 34'h1000);
    idle(); fault_clear = 1'b1;
    cycle("clr1");
    fault_clear = 1'b0;

    // TOR region 3 beats NAPOT region 5; boundary at the TOR top
    paddr[2] = 34'h2000; paddr[3] = 34'h3000; cfg[3] = mk_cfg(1'b0, PMP_MODE_TOR, 1'b1, 1'b0, 1'b0);
    paddr[5] = 34'h2FFC; cfg[5] = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    set_req(0, 34'h2800, PMP_ACC_WRITE, PRIV_LVL_U);
    cycle("tor_w");
    chk("tor_w err", rsp_err[0], 1'b1);
    chk("tor_w region", rsp_region[0], 4'd3);
    set_req(0, 34'h3000, PMP_ACC_READ, PRIV_LVL_U);
    cycle("napot_r");
    chk("napot_r err", rsp_err[0], 1'b0);
    chk("napot_r region", rsp_region[0], 4'd5);
    set_req(0, 34'h2FFF, PMP_ACC_READ, PRIV_LVL_U);
    cycle("tor_edge");
    chk("tor_edge region", rsp_region[0], 4'd3);
    set_req(0, 34'h1FFC, PMP_ACC_READ, PRIV_LVL_U);
    cycle("below");

    // MML with a shared read-only region covering everything
    clear_csrs();
    msec.mml = 1'b1;
    paddr[0] = '1; cfg[0] = mk_cfg(1'b1, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    set_req(0, 34'h500, PMP_ACC_EXEC, PRIV_LVL_M);
    cycle("mml_mx");
    chk("mml_mx err", rsp_err[0], 1'b1);
    set_req(0, 34'h500, PMP_ACC_READ, PRIV_LVL_S);
    cycle("mml_sr");
    chk("mml_sr err", rsp_err[0], 1'b0);
    idle(); fault_clear = 1'b1;
    cycle("clr2");
    fault_clear = 1'b0;
    chk("clr2 fault_valid", fault_valid, 1'b0);

    // Both channels fault together
    set_req(0, 34'h600, PMP_ACC_EXEC, PRIV_LVL_U);
    set_req(1, 34'h700, PMP_ACC_EXEC, PRIV_LVL_S);
    cycle("dual");
    chk("dual fault_chan", fault_chan, 1'd0);
    chk("dual overflow", fault_overflow, 1'b1);
    idle(); fault_clear = 1'b1;
    cycle("clr3");
    fault_clear = 1'b0;
    chk("clr3 valid", fault_valid, 1'b0);
    chk("clr3 overflow", fault_overflow, 1'b0);

    // Channel 1 stalled while its region is rewritten; channel 0 streams
    clear_csrs();
    paddr[0] = '1; cfg[0] = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
    rsp_ready[1] = 1'b0;
    set_req(1, 34'h40, PMP_ACC_READ, PRIV_LVL_U);
    set_req(0, 34'h80, PMP_ACC_READ, PRIV_LVL_U);
    cycle("stall0");
    for (int i = 0; i < 3; i++) begin
      cfg[0] = mk_cfg(1'b0, PMP_MODE_NAPOT, 1'b0, 1'b0, 1'b0);
      set_req(1, AW'(34'h100 + i * 4), PMP_ACC_WRITE, PRIV_LVL_U);
      set_req(0, AW'(34'h200 + i * 4), PMP_ACC_READ, PRIV_LVL_U);
      cycle($sformatf("stall%0d", i + 1));
      chk("stall ready1", req_ready[1], 1'b0);
      chk("stall ready0", req_ready[0], 1'b1);
      chk("stall err1", rsp_err[1], 1'b0);
      chk("stall valid0", rsp_valid[0], 1'b1);
    end
    rsp_ready[1] = 1'b1;
    cycle("unstall");

    // Reset with both stages full and a fault held
    rsp_ready = '0;
    set_req(0, 34'h300, PMP_ACC_EXEC, PRIV_LVL_U);
    set_req(1, 34'h304, PMP_ACC_READ, PRIV_LVL_S);
    cycle("prefill");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid");
    reset_model();
    idle();
    #1;
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) rand_csrs();
      for (int c = 0; c < NC; c++) begin
        req_valid[c] = ($urandom_range(0, 3) != 0);
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) req_addr[c] = {$urandom_range(0, 3), $urandom()};
        else req_addr[c] = AW'($urandom_range(0, 32'h5400));
        req_type[c] = pmp_req_e'($urandom_range(0, 2));
        priv[c] = rand_priv();
      end
      fault_clear = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
